// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------
// pc_sequencer_pkg: shared FSM encoding and default parameters. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_CNT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_sat_counter.sv
// ----------------------------------------------------------------------
// sat_counter: up-counter that sticks at all-ones instead of wrapping. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en && inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------
// pc_sequencer: fetch PC sequencer with RUN/REDIRECT/HALT control. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             wtg_valid,
  input  logic [31:0]      wtg_pc_new,
  input  logic             wtg_branched,
  input  logic             wtg_is_jump,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             flush_if,
  output logic             flush_id,
  output logic             halted,
  output logic             align_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        align_err_q;
  logic        redirect_w;
  logic        accept_w;

  assign pc_4       = pc_q + 32'd4;
  assign redirect_w = (state_q == ST_RUN) && wtg_valid && (wtg_branched || wtg_is_jump);
  assign accept_w   = en && redirect_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_RUN: begin
          // A redirect outranks both halt and stall in the same cycle.
          if (redirect_w) begin
            pc_q    <= {wtg_pc_new[31:2], 2'b00};
            state_q <= ST_REDIRECT;
            if (wtg_pc_new[1:0] != 2'b00) align_err_q <= 1'b1;
          end else if (halt) begin
            state_q <= ST_HALT;
          end else if (!stall) begin
            pc_q <= pc_4;
          end
        end
        ST_REDIRECT: begin
          if (!stall) pc_q <= pc_4;
          state_q <= ST_RUN;
        end
        ST_HALT: begin
          if (resume) begin
            pc_q    <= pc_4;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Flushes are gated by en so a frozen pipeline never sees a squash.
  assign flush_if  = en && (state_q == ST_REDIRECT);
  assign flush_id  = en && (state_q == ST_REDIRECT);
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;
  assign align_err = align_err_q;

  sat_counter #(.WIDTH(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (accept_w && wtg_branched && !wtg_is_jump),
    .count (taken_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_jump_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (accept_w && wtg_is_jump),
    .count (jump_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------
// tb_pc_sequencer: directed self-checking bench for pc_sequencer. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, stall, halt, resume;
  logic        wtg_valid, wtg_branched, wtg_is_jump;
  logic [31:0] wtg_pc_new;

  logic [31:0] pc, pc_4, pc2, pc2_4;
  logic        flush_if, flush_id, halted, align_err;
  logic        flush_if2, flush_id2, halted2, align_err2;
  logic [15:0] taken_cnt, jump_cnt;
  logic [1:0]  taken_cnt2, jump_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .halt(halt), .resume(resume),
    .wtg_valid(wtg_valid), .wtg_pc_new(wtg_pc_new), .wtg_branched(wtg_branched),
    .wtg_is_jump(wtg_is_jump), .pc(pc), .pc_4(pc_4), .flush_if(flush_if),
    .flush_id(flush_id), .halted(halted), .align_err(align_err),
    .taken_cnt(taken_cnt), .jump_cnt(jump_cnt)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .halt(halt), .resume(resume),
    .wtg_valid(wtg_valid), .wtg_pc_new(wtg_pc_new), .wtg_branched(wtg_branched),
    .wtg_is_jump(wtg_is_jump), .pc(pc2), .pc_4(pc2_4), .flush_if(flush_if2),
    .flush_id(flush_id2), .halted(halted2), .align_err(align_err2),
    .taken_cnt(taken_cnt2), .jump_cnt(jump_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; halt = 0; resume = 0;
    wtg_valid = 0; wtg_branched = 0; wtg_is_jump = 0; wtg_pc_new = '0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; idle_inputs();
    #2;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if ({flush_if, flush_id, halted, align_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {flush_if, flush_id, halted, align_err}); end
    n_checks++; if ({taken_cnt, jump_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", {taken_cnt, jump_cnt}); end
    n_checks++; if (pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc2: got %h want fffffffc", pc2); end
    step();
    rst = 0;
    #1;
    n_checks++; if (pc_4 !== 32'h4) begin n_fail++; $display("FAIL pc_4_comb: got %h want 4", pc_4); end
    n_checks++; if (pc2_4 !== 32'h0) begin n_fail++; $display("FAIL pc2_4_wrap: got %h want 0", pc2_4); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL run_free[%0d]: got %h want %h", i, pc, 32'(4 * i)); end
      n_checks++; if ({flush_if, flush_id} !== 2'b00) begin n_fail++; $display("FAIL run_flush[%0d]: got %b want 00", i, {flush_if, flush_id}); end
      n_checks++; if (pc2 !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL wrap[%0d]: got %h want %h", i, pc2, 32'(4 * (i - 1))); end
    end
    n_checks++; if ({taken_cnt, jump_cnt} !== 32'h0) begin n_fail++; $display("FAIL run_cnt: got %h want 0", {taken_cnt, jump_cnt}); end
  endtask

  task automatic test_branch();
    step();
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL pre_branch_pc: got %h want 10", pc); end
    wtg_valid = 1; wtg_branched = 1; wtg_pc_new = 32'h40;
    step();
    idle_inputs();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL branch_pc: got %h want 40", pc); end
    n_checks++; if ({flush_if, flush_id} !== 2'b11) begin n_fail++; $display("FAIL branch_flush: got %b want 11", {flush_if, flush_id}); end
    n_checks++; if (taken_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_taken: got %0d want 1", taken_cnt); end
    step();
    n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL branch_after_pc: got %h want 44", pc); end
    n_checks++; if ({flush_if, flush_id} !== 2'b00) begin n_fail++; $display("FAIL branch_after_flush: got %b want 00", {flush_if, flush_id}); end
  endtask

  task automatic test_redirect_halt();
    wtg_valid = 1; wtg_branched = 1; wtg_pc_new = 32'h80; halt = 1;
    step();
    wtg_valid = 0; wtg_branched = 0;
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL rh_pc: got %h want 80", pc); end
    n_checks++; if ({flush_if, halted} !== 2'b10) begin n_fail++; $display("FAIL rh_state: got flush,halted=%b want 10", {flush_if, halted}); end
    step();
    halt = 0;
    n_checks++; if (pc !== 32'h84) begin n_fail++; $display("FAIL rh_after_pc: got %h want 84", pc); end
    n_checks++; if ({flush_if, halted} !== 2'b00) begin n_fail++; $display("FAIL rh_after_state: got %b want 00", {flush_if, halted}); end
  endtask

  task automatic test_halt();
    wtg_valid = 1; wtg_branched = 1; wtg_pc_new = 32'h20;
    step();
    idle_inputs();
    stall = 1;
    step();
    stall = 0;
    n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL redirect_stall_pc: got %h want 20", pc); end
    halt = 1;
    step();
    halt = 0;
    wtg_valid = 1; wtg_is_jump = 1; wtg_pc_new = 32'h500;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({halted, pc} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL halt_hold[%0d]: got halted=%b pc=%h want 1/20", i, halted, pc); end
      if (i < 4) step();
    end
    idle_inputs();
    resume = 1;
    step();
    resume = 0;
    n_checks++; if ({halted, pc} !== {1'b0, 32'h24}) begin n_fail++; $display("FAIL resume: got halted=%b pc=%h want 0/24", halted, pc); end
    n_checks++; if (jump_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_ignores_jump: got %0d want 0", jump_cnt); end
  endtask

  task automatic test_jump_align();
    wtg_valid = 1; wtg_is_jump = 1; wtg_pc_new = 32'h103;
    step();
    idle_inputs();
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jump_pc: got %h want 100", pc); end
    n_checks++; if ({align_err, jump_cnt} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL jump_align_cnt: got %b/%0d want 1/1", align_err, jump_cnt); end
    n_checks++; if (taken_cnt !== 16'd3) begin n_fail++; $display("FAIL jump_not_taken: got %0d want 3", taken_cnt); end
    step();
    step();
    n_checks++; if ({align_err, pc} !== {1'b1, 32'h108}) begin n_fail++; $display("FAIL align_sticky: got %b/%h want 1/108", align_err, pc); end
  endtask

  task automatic test_enable();
    en = 0; wtg_valid = 1; wtg_branched = 1; wtg_pc_new = 32'h300;
    step();
    n_checks++; if ({pc, flush_if, taken_cnt} !== {32'h108, 1'b0, 16'd3}) begin n_fail++; $display("FAIL en0_freeze: got pc=%h flush=%b taken=%0d want 108/0/3", pc, flush_if, taken_cnt); end
    en = 1;
    step();
    idle_inputs();
    n_checks++; if ({pc, flush_if} !== {32'h300, 1'b1}) begin n_fail++; $display("FAIL en1_redirect: got %h/%b want 300/1", pc, flush_if); end
    en = 0;
    #1;
    n_checks++; if ({flush_if, flush_id} !== 2'b00) begin n_fail++; $display("FAIL en0_flush_gate: got %b want 00", {flush_if, flush_id}); end
    step();
    en = 1;
    #1;
    n_checks++; if ({pc, flush_if} !== {32'h300, 1'b1}) begin n_fail++; $display("FAIL en_resume_redirect: got %h/%b want 300/1", pc, flush_if); end
    step();
    n_checks++; if ({pc, flush_if} !== {32'h304, 1'b0}) begin n_fail++; $display("FAIL en_after: got %h/%b want 304/0", pc, flush_if); end
  endtask

  task automatic test_saturation_reset();
    wtg_valid = 1; wtg_branched = 1; wtg_pc_new = 32'h200;
    step();
    idle_inputs();
    n_checks++; if (taken_cnt !== 16'd5) begin n_fail++; $display("FAIL taken_count: got %0d want 5", taken_cnt); end
    n_checks++; if (taken_cnt2 !== 2'd3) begin n_fail++; $display("FAIL taken_saturate: got %0d want 3", taken_cnt2); end
    n_checks++; if ({flush_if, flush_id} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_flush: got %b want 11", {flush_if, flush_id}); end
    rst = 1;
    #1;
    n_checks++; if ({flush_if, flush_id, pc} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL async_reset: got flush=%b pc=%h want 00/0", {flush_if, flush_id}, pc); end
    n_checks++; if ({align_err, taken_cnt, jump_cnt} !== 33'h0) begin n_fail++; $display("FAIL reset_clears: got %b/%0d/%0d want 0/0/0", align_err, taken_cnt, jump_cnt); end
    step();
    rst = 0;
    step();
    n_checks++; if ({pc, flush_if} !== {32'h4, 1'b0}) begin n_fail++; $display("FAIL post_reset_fetch: got %h/%b want 4/0", pc, flush_if); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_redirect_halt();
    test_halt();
    test_jump_align();
    test_enable();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
